piece_render_sched: RTL and testbench

- Per-scanline scheduler that sequences the piece sprite datapath for the 8x8 board.
- During horizontal blanking it prefetches the eight piece codes of the upcoming board line from the board-state RAM into a line buffer.
- During active video it tracks square column/row with counters and emits, one vga_clk after each pixel:
  - the piece code to select the sprite ROM/palette,
  - the 55x55 sprite ROM address,
  - the sprite-on and square-colour flags.
- It sits between the VGA controller and the per-piece sprite ROM instances.

---
 rtl/piece_render_sched_if.sv | 9 +
 rtl/piece_render_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_piece_render_sched.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/piece_render_sched_if.sv
// Board-state RAM read bus between the piece scheduler (master) and the RAM (slave).
interface piece_render_sched_if;
  logic       board_rd;
  logic [5:0] board_addr;
  logic [3:0] board_q;

  modport master (output board_rd, output board_addr, input board_q);
  modport slave  (input board_rd, input board_addr, output board_q);
endinterface

// File: rtl/piece_render_sched.sv
// Per-scanline piece sprite scheduler for the 8x8 board: line prefetch in hblank, pixel outputs in active video.
// Defining PIECE_CURSOR_EN adds the cursor_sq/cursor_en inputs and the cursor_on border output.
module piece_render_sched #(
  parameter int BOARD_X = 80,
  parameter int BOARD_Y = 0,
  parameter int SQ      = 60,
  parameter int SPR     = 55,
  parameter int PAD     = 2,
  parameter int FETCH_X = 640,
  parameter int V_TOTAL = 525
) (
  input  logic                 vga_clk,
  input  logic                 Reset,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  piece_render_sched_if.master board,
  output logic                 fetch_busy,
  output logic [3:0]           piece_code,
  output logic [11:0]          sprite_addr,
  output logic                 sprite_on,
  output logic                 board_on,
  output logic                 square_dark
`ifdef PIECE_CURSOR_EN
  ,
  input  logic [5:0]           cursor_sq,
  input  logic                 cursor_en,
  output logic                 cursor_on
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [9:0]  X_START = 10'(BOARD_X);
  localparam logic [9:0]  Y_START = 10'(BOARD_Y);
  localparam logic [9:0]  X_FETCH = 10'(FETCH_X);
  localparam logic [9:0]  Y_LAST  = 10'(V_TOTAL - 1);
  localparam logic [5:0]  SQ_LAST = 6'(SQ - 1);
  localparam logic [5:0]  PAD_LO  = 6'(PAD);
  localparam logic [5:0]  PAD_HI  = 6'(PAD + SPR);
  localparam logic [11:0] PAD_W   = 12'(PAD);
  localparam logic [11:0] SPR_W   = 12'(SPR);

  function automatic logic in_span(input logic [9:0] v, input int lo, input int len);
    int vi;
    vi = int'({22'd0, v});
    return (vi >= lo) && (vi < lo + len);
  endfunction

  logic [9:0]  next_y_s;
  logic        next_in_s, in_x_s, in_y_s, fetch_trig_s;
  logic [2:0]  row_r, row_s, col_r, col_s;
  logic [5:0]  ry_r, ry_s, cx_r, cx_s;
  state_t      state_r, state_s;
  logic [2:0]  idx_r, idx_s, wr_idx_r;
  logic        rd_s, board_rd_r, busy_s, busy_r, wr_en_r;
  logic [5:0]  addr_s, board_addr_r;
  logic [3:0]  linebuf_r [8];
  logic [3:0]  code_s, piece_s, piece_r;
  logic        on_s, pix_in_s, spr_on_s, dark_s;
  logic        on_r, spr_on_r, dark_r;
  logic [11:0] saddr_s, saddr_r;

  // Line geometry and row/column counter next values
  always_comb begin
    next_y_s     = (DrawY == Y_LAST) ? 10'd0 : DrawY + 10'd1;
    next_in_s    = in_span(next_y_s, BOARD_Y, 8 * SQ);
    in_x_s       = in_span(DrawX, BOARD_X, 8 * SQ);
    in_y_s       = in_span(DrawY, BOARD_Y, 8 * SQ);
    fetch_trig_s = (DrawX == X_FETCH);
    row_s        = row_r;
    ry_s         = ry_r;
    col_s        = col_r;
    cx_s         = cx_r;
    if (fetch_trig_s && (next_y_s == Y_START)) begin
      row_s = 3'd0;
      ry_s  = 6'd0;
    end else if (fetch_trig_s && next_in_s) begin
      if (ry_r == SQ_LAST) begin
        ry_s  = 6'd0;
        row_s = row_r + 3'd1;
      end else begin
        ry_s  = ry_r + 6'd1;
      end
    end else begin
      row_s = row_r;
      ry_s  = ry_r;
    end
    if (DrawX == X_START) begin
      col_s = 3'd0;
      cx_s  = 6'd0;
    end else if (in_x_s) begin
      if (cx_r == SQ_LAST) begin
        cx_s  = 6'd0;
        col_s = col_r + 3'd1;
      end else begin
        cx_s  = cx_r + 6'd1;
      end
    end else begin
      col_s = col_r;
      cx_s  = cx_r;
    end
  end

  // Prefetch FSM next state; read strobe and address are registered with the state
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    rd_s    = 1'b0;
    addr_s  = 6'd0;
    case (state_r)
      IDLE: begin
        if (fetch_trig_s && next_in_s) begin
          state_s = READ;
          idx_s   = 3'd0;
          rd_s    = 1'b1;
          addr_s  = {row_s, 3'd0};
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (idx_r == 3'd7) begin
          state_s = DRAIN;
        end else begin
          idx_s  = idx_r + 3'd1;
          rd_s   = 1'b1;
          addr_s = {row_r, idx_s};
        end
      end
      DRAIN:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
    busy_s = (state_s != IDLE);
  end

  // Prefetch state register; the line-buffer write trails each read by one cycle
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_r      <= IDLE;
      idx_r        <= 3'd0;
      board_rd_r   <= 1'b0;
      board_addr_r <= 6'd0;
      busy_r       <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_idx_r     <= 3'd0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      board_rd_r   <= rd_s;
      board_addr_r <= addr_s;
      busy_r       <= busy_s;
      wr_en_r      <= board_rd_r;
      wr_idx_r     <= board_addr_r[2:0];
    end
  end

  // Line buffer of the eight piece codes for the current board line
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) linebuf_r[i] <= 4'd0;
    end else if (wr_en_r) begin
      linebuf_r[wr_idx_r] <= board.board_q;
    end
  end

  // Pixel output terms for the current DrawX/DrawY
  always_comb begin
    on_s     = in_x_s & in_y_s;
    pix_in_s = (cx_s >= PAD_LO) && (cx_s < PAD_HI) && (ry_r >= PAD_LO) && (ry_r < PAD_HI);
    code_s   = linebuf_r[col_s];
    piece_s  = on_s ? code_s : 4'd0;
    spr_on_s = on_s & pix_in_s & (code_s != 4'd0);
    dark_s   = on_s & (row_r[0] ^ col_s[0]);
    saddr_s  = spr_on_s ? (({6'd0, cx_s} - PAD_W) + ({6'd0, ry_r} - PAD_W) * SPR_W) : 12'd0;
  end

  // Counter state and the single output register stage
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      row_r    <= 3'd0;
      ry_r     <= 6'd0;
      col_r    <= 3'd0;
      cx_r     <= 6'd0;
      on_r     <= 1'b0;
      spr_on_r <= 1'b0;
      dark_r   <= 1'b0;
      piece_r  <= 4'd0;
      saddr_r  <= 12'd0;
    end else begin
      row_r    <= row_s;
      ry_r     <= ry_s;
      col_r    <= col_s;
      cx_r     <= cx_s;
      on_r     <= on_s;
      spr_on_r <= spr_on_s;
      dark_r   <= dark_s;
      piece_r  <= piece_s;
      saddr_r  <= saddr_s;
    end
  end

`ifdef PIECE_CURSOR_EN
  logic cursor_s, cursor_r;

  // Cursor border: the PAD-wide frame around the selected square
  always_comb begin
    cursor_s = on_s & cursor_en & ({row_r, col_s} == cursor_sq) & ~pix_in_s;
  end

  // Cursor output register, aligned with the other pixel outputs
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      cursor_r <= 1'b0;
    end else begin
      cursor_r <= cursor_s;
    end
  end

  assign cursor_on = cursor_r;
`endif

  assign board.board_rd   = board_rd_r;
  assign board.board_addr = board_addr_r;
  assign fetch_busy       = busy_r;
  assign piece_code       = piece_r;
  assign sprite_addr      = saddr_r;
  assign sprite_on        = spr_on_r;
  assign board_on         = on_r;
  assign square_dark      = dark_r;

endmodule

// File: tb/tb_piece_render_sched.sv
// Directed bench for piece_render_sched: reset, prefetch, sprite hits, row/square, cursor, reset mid-fetch.
module tb_piece_render_sched;
  logic        vga_clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        fetch_busy, sprite_on, board_on, square_dark;
  logic [3:0]  piece_code;
  logic [11:0] sprite_addr;
`ifdef PIECE_CURSOR_EN
  logic [5:0]  cursor_sq;
  logic        cursor_en, cursor_on;
`endif
  logic [3:0]  mem [64];
  int          n_checks = 0;
  int          n_fail = 0;

  piece_render_sched_if bus ();

  piece_render_sched dut (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .board(bus),
    .fetch_busy(fetch_busy), .piece_code(piece_code), .sprite_addr(sprite_addr),
    .sprite_on(sprite_on), .board_on(board_on), .square_dark(square_dark)
`ifdef PIECE_CURSOR_EN
    , .cursor_sq(cursor_sq), .cursor_en(cursor_en), .cursor_on(cursor_on)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  // Board-state RAM: data valid the cycle after the read strobe
  always @(posedge vga_clk) begin
    if (bus.board_rd) bus.board_q <= mem[bus.board_addr];
  end

  task automatic tick(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(posedge vga_clk);
    #1;
  endtask

  task automatic advance(input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = 636; x <= 652; x++) tick(x, y);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    for (int x = 100; x <= 101; x++) begin
      tick(x, 0);
      n_checks++;
      if ({board_on, sprite_on, square_dark, piece_code, sprite_addr, bus.board_rd, fetch_busy} !== 21'd0) begin
        n_fail++;
        $display("FAIL reset_outputs x=%0d got on=%b son=%b dark=%b pc=%0d sa=%0d rd=%b busy=%b required all 0",
                 x, board_on, sprite_on, square_dark, piece_code, sprite_addr, bus.board_rd, fetch_busy);
      end
    end
    Reset = 1'b0;
    for (int x = 78; x <= 565; x++) begin
      tick(x, 0);
      n_checks++;
      if (board_on !== ((x >= 80 && x < 560) ? 1'b1 : 1'b0) || piece_code !== 4'd0 || sprite_on !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_linebuf x=%0d got on=%b pc=%0d son=%b required on=%b pc=0 son=0",
                 x, board_on, piece_code, sprite_on, (x >= 80 && x < 560));
      end
    end
  endtask

  task automatic test_prefetch;
    int rd_cnt = 0, busy_cnt = 0, exp_idx = 0, first_x = -1;
    for (int x = 630; x <= 660; x++) begin
      tick(x, 524);
      if (bus.board_rd === 1'b1) begin
        if (first_x < 0) first_x = x;
        rd_cnt++;
        n_checks++;
        if (bus.board_addr !== 6'(exp_idx)) begin
          n_fail++;
          $display("FAIL prefetch_addr x=%0d got %0d required %0d", x, bus.board_addr, exp_idx);
        end
        exp_idx++;
      end
      if (fetch_busy === 1'b1) busy_cnt++;
    end
    n_checks++;
    if (rd_cnt !== 8) begin
      n_fail++;
      $display("FAIL prefetch_rd_cycles got %0d required 8", rd_cnt);
    end
    n_checks++;
    if (busy_cnt !== 9) begin
      n_fail++;
      $display("FAIL prefetch_busy_cycles got %0d required 9", busy_cnt);
    end
    n_checks++;
    if (first_x !== 640) begin
      n_fail++;
      $display("FAIL prefetch_start got x=%0d required 640", first_x);
    end
  endtask

  task automatic test_sprite_hit;
    int xs [9]  = '{79, 82, 136, 137, 150, 200, 230, 559, 560};
    int pc [9]  = '{0, 5, 5, 5, 0, 7, 7, 0, 0};
    int son [9] = '{0, 1, 1, 0, 0, 0, 1, 0, 0};
    int bon [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int sa [9]  = '{0, 0, 54, 0, 0, 0, 28, 0, 0};
    int dk [9]  = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
    advance(0, 1);
    for (int x = 0; x <= 700; x++) begin
      tick(x, 2);
      for (int k = 0; k < 9; k++) begin
        if (x == xs[k]) begin
          n_checks++;
          if (piece_code !== 4'(pc[k]) || sprite_on !== 1'(son[k]) || board_on !== 1'(bon[k]) ||
              sprite_addr !== 12'(sa[k]) || square_dark !== 1'(dk[k])) begin
            n_fail++;
            $display("FAIL sprite_hit x=%0d got pc=%0d son=%b on=%b sa=%0d dark=%b required pc=%0d son=%0d on=%0d sa=%0d dark=%0d",
                     x, piece_code, sprite_on, board_on, sprite_addr, square_dark, pc[k], son[k], bon[k], sa[k], dk[k]);
          end
        end
      end
    end
  endtask

  task automatic test_cursor;
`ifdef PIECE_CURSOR_EN
    int xs [5] = '{79, 81, 100, 139, 140};
    int cv [5] = '{0, 1, 0, 1, 0};
    cursor_sq = 6'd0;
    cursor_en = 1'b1;
    for (int x = 0; x <= 700; x++) begin
      tick(x, 30);
      for (int k = 0; k < 5; k++) begin
        if (x == xs[k]) begin
          n_checks++;
          if (cursor_on !== 1'(cv[k])) begin
            n_fail++;
            $display("FAIL cursor_border x=%0d got %b required %0d", x, cursor_on, cv[k]);
          end
        end
      end
    end
    cursor_en = 1'b0;
    for (int x = 0; x <= 700; x++) begin
      tick(x, 31);
      n_checks++;
      if (cursor_on !== 1'b0) begin
        n_fail++;
        $display("FAIL cursor_disabled x=%0d got %b required 0", x, cursor_on);
      end
    end
`else
    advance(30, 31);
`endif
  endtask

  task automatic test_row_square;
    int xs [5]  = '{79, 80, 142, 170, 560};
    int pc [5]  = '{0, 0, 3, 3, 0};
    int son [5] = '{0, 0, 1, 1, 0};
    int bon [5] = '{0, 1, 1, 1, 0};
    int sa [5]  = '{0, 0, 0, 28, 0};
    int dk [5]  = '{0, 1, 0, 0, 0};
    advance(32, 61);
    for (int x = 0; x <= 700; x++) begin
      tick(x, 62);
      for (int k = 0; k < 5; k++) begin
        if (x == xs[k]) begin
          n_checks++;
          if (piece_code !== 4'(pc[k]) || sprite_on !== 1'(son[k]) || board_on !== 1'(bon[k]) ||
              sprite_addr !== 12'(sa[k]) || square_dark !== 1'(dk[k])) begin
            n_fail++;
            $display("FAIL row_square x=%0d got pc=%0d son=%b on=%b sa=%0d dark=%b required pc=%0d son=%0d on=%0d sa=%0d dark=%0d",
                     x, piece_code, sprite_on, board_on, sprite_addr, square_dark, pc[k], son[k], bon[k], sa[k], dk[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_fetch;
    for (int x = 630; x <= 643; x++) tick(x, 524);
    n_checks++;
    if (bus.board_rd !== 1'b1 || fetch_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midfetch_active got rd=%b busy=%b required 1 1", bus.board_rd, fetch_busy);
    end
    Reset = 1'b1;
    tick(644, 524);
    Reset = 1'b0;
    n_checks++;
    if (bus.board_rd !== 1'b0 || fetch_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midfetch_abort got rd=%b busy=%b required 0 0", bus.board_rd, fetch_busy);
    end
    for (int x = 645; x <= 660; x++) begin
      tick(x, 524);
      n_checks++;
      if (bus.board_rd !== 1'b0 || fetch_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midfetch_no_rd x=%0d got rd=%b busy=%b required 0 0", x, bus.board_rd, fetch_busy);
      end
    end
    for (int x = 78; x <= 565; x++) begin
      tick(x, 0);
      n_checks++;
      if (piece_code !== 4'd0 || sprite_on !== 1'b0) begin
        n_fail++;
        $display("FAIL midfetch_linebuf x=%0d got pc=%0d son=%b required 0 0", x, piece_code, sprite_on);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 4'd0;
    mem[0] = 4'd5;
    mem[2] = 4'd7;
    mem[9] = 4'd3;
    Reset = 1'b1;
    DrawX = 10'd0;
    DrawY = 10'd0;
`ifdef PIECE_CURSOR_EN
    cursor_sq = 6'd0;
    cursor_en = 1'b0;
`endif
    test_reset();
    test_prefetch();
    test_sprite_hit();
    advance(3, 29);
    test_cursor();
    test_row_square();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
